store_uart_tx: RTL and testbench
================================

# store_uart_tx

Downstream consumer of the CPU's store port: captures each 32-bit word presented on `data_out` when `store_data_out` strobes, queues it in a small FIFO, and serialises it as four 8N1 UART bytes, least-significant byte first. Instantiated beside `nanoV_cpu` in the test harness and top level so that program output (debug prints, test signatures) appears on a single pin without stalling the core.

## Interface
- `CLK_DIV`, 16: clock cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, 4: word entries; power of two, 2..16.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `data_out`  in  32  store word from the CPU.
- `store_data_out`  in  1  store strobe; each high cycle is one push of `data_out`.
- `clear_ovf`  in  1  synchronous clear of `overflow`.
- `uart_tx`  out  1  serial line, idle high.
- `busy`  out  1  high while FIFO is non-empty or a frame is in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words queued; excludes the word being transmitted.
- `overflow`  out  1  sticky; set when a push is dropped.

## Operation
- Reset values: `uart_tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0; FSM in IDLE; all counters 0.
- Push: `store_data_out`=1 and FIFO not full → word written. If full and no pop in the same cycle → word dropped, `overflow` set.
- Simultaneous push and pop with FIFO full → push accepted; count unchanged.
- `overflow` set and `clear_ovf` in the same cycle → `overflow` stays 1, because set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if `fifo_count`>0, pop the head into the 32-bit shift register, set byte_idx=0, go to START.
  - START: `uart_tx`=0 for CLK_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: `uart_tx`=current byte bit[bit_idx], LSB first, CLK_DIV cycles per bit. After bit 7, go to STOP.
  - STOP: `uart_tx`=1 for CLK_DIV cycles. Then, if byte_idx<3, increment byte_idx, shift the word right 8 and go to START. Otherwise go to IDLE.
- Baud counter counts 0..CLK_DIV-1; it resets on every state or bit change.
- `busy` = (state≠IDLE) | (`fifo_count`≠0).
- Asserting `rstn` low mid-frame aborts the frame immediately. `uart_tx` returns to 1 asynchronously and the FIFO is emptied.

## Timing
- Strobe in cycle N with FIFO empty and FSM idle: `fifo_count`=1 at N+1 and IDLE pops at N+1. START is entered at N+2, so `uart_tx` falls at N+2.
- One byte frame is 10·CLK_DIV cycles; one word is 40·CLK_DIV cycles.
- Between bytes of the same word there is no gap: STOP→START is immediate.
- Between words there is exactly 1 idle-high cycle (the IDLE pop cycle) beyond the stop bit.
- Sustained throughput is one word per 40·CLK_DIV+1 cycles. A faster store rate fills the FIFO, then overflows.
- `fifo_count` decrements in the cycle after the IDLE pop.

## Structure
- Shared package `nanoV_uart_pkg`:
  - state enum (IDLE, START, DATA, STOP);
  - constants `UART_DATA_BITS`=8 and `UART_BYTES_PER_WORD`=4.
- Sub-module `word_fifo`: synchronous FIFO.
  - Parameters: WIDTH and DEPTH.
  - Ports: push, pop, full, empty, count, wdata, rdata.
  - Read data is valid combinationally at the head.
  - Pointer wrap uses an extra MSB for the full/empty distinction.
- Top level holds the FSM, the baud counter, bit_idx, byte_idx, the shift register and the overflow flag.

## Test plan
- Single store, CLK_DIV=4, word 0x44332211 → `uart_tx` falls 2 cycles after the strobe. The decoded byte sequence is 0x11, 0x22, 0x33, 0x44, each bit exactly 4 cycles wide. `busy` drops 160 cycles after the first fall.
- Two back-to-back strobes 0xA5A5A5A5 then 0x0000FF00 → eight correct bytes. Exactly one extra high cycle between byte 4 and byte 5. `fifo_count` goes 1, 2, 1, 0.
- FIFO_DEPTH=4, six strobes in consecutive cycles while idle:
  - the first pops at once and four are queued, so `fifo_count`=4;
  - the sixth is dropped and `overflow`=1;
  - only five words are transmitted.
- Push with FIFO full in the IDLE pop cycle → push accepted, `fifo_count` stays at DEPTH, and `overflow` stays 0.
- `clear_ovf` pulse → `overflow` returns to 0. `clear_ovf` together with a dropped push → `overflow` stays 1.
- `rstn` low during the DATA bit of byte 2 → `uart_tx`=1 and `fifo_count`=0 without waiting for a clock edge. After release, a new store transmits correctly from byte 0.

Source files
------------

// File: rtl/nanoV_uart_pkg.sv
// Shared definitions for the store-port UART transmitter.
//   uart_state_e        : transmitter FSM states
//   UART_DATA_BITS      : data bits per serial frame
//   UART_BYTES_PER_WORD : bytes sent per captured 32-bit word
package nanoV_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with combinational head read.
//   clk, rstn : clock, asynchronous active-low reset (pointers only)
//   push      : write wdata; accepted when not full, or when full and popping
//   pop       : discard the head word (ignored when empty)
//   wdata     : word to write
//   rdata     : current head word, valid whenever empty is low
//   full      : DEPTH words stored
//   empty     : no words stored
//   count     : number of words stored (0..DEPTH)
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so equal addresses can be told apart as
  // empty (MSBs equal) or full (MSBs differ).
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // When full, a pop frees the head slot in the same edge, so the write
  // lands in the slot being vacated.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/store_uart_tx.sv
// Captures CPU store words into a FIFO and sends each as four 8N1 bytes,
// least-significant byte first, on a single serial pin.
//   clk, rstn      : clock, asynchronous active-low reset
//   data_out       : store word from the CPU
//   store_data_out : one push of data_out per high cycle
//   clear_ovf      : synchronous clear of overflow (a same-cycle drop wins)
//   uart_tx        : serial line, idle high
//   busy           : frame in progress or words queued
//   fifo_count     : words queued, excluding the one being sent
//   overflow       : sticky, set when a push is dropped
//   state_dbg      : current transmitter FSM state
// Handshake: there is no back-pressure; a strobe is accepted when the FIFO
// has room or is popped in the same cycle, otherwise dropped and flagged.
module store_uart_tx
  import nanoV_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [31:0]                   data_out,
  input  logic                          store_data_out,
  input  logic                          clear_ovf,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output uart_state_e                   state_dbg
);

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [1:0]  BYTE_LAST = 2'(UART_BYTES_PER_WORD - 1);

  uart_state_e state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_idx, bit_n;
  logic [1:0]  byte_idx, byte_n;
  logic [31:0] shift_reg, shift_n;
  logic        baud_done;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic [7:0]  cur_byte;

  word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (store_data_out),
    .pop   (pop),
    .wdata (data_out),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign cur_byte  = shift_reg[7:0];
  assign busy      = (state != IDLE) | (fifo_count != '0);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      byte_idx  <= byte_n;
      shift_reg <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    shift_n = shift_reg;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_rdata;
          byte_n  = '0;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == BIT_LAST) state_n = STOP;
          else                     bit_n   = bit_idx + 3'd1;
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          // Next byte of the same word follows with no idle gap.
          if (byte_idx != BYTE_LAST) begin
            byte_n  = byte_idx + 2'd1;
            shift_n = shift_reg >> UART_DATA_BITS;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Decoded from state so the line returns high as soon as reset asserts.
  always_comb begin
    uart_tx = 1'b1;
    case (state)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = cur_byte[bit_idx];
      default: uart_tx = 1'b1;
    endcase
  end

  // A dropped push takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (store_data_out && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_store_uart_tx.sv
// Bench for store_uart_tx: directed timing scenarios plus random word
// bursts, with a serial-line receiver model checking every bit cycle.
module tb_store_uart_tx;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rstn;
  logic [31:0]   data_out;
  logic          store_data_out;
  logic          clear_ovf;
  logic          uart_tx;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];   // bytes expected on the line, in order
  int         gap_q[$];   // idle-high cycles seen before each frame

  store_uart_tx #(
    .CLK_DIV    (D),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .data_out       (data_out),
    .store_data_out (store_data_out),
    .clear_ovf      (clear_ovf),
    .uart_tx        (uart_tx),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void expect_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
  endfunction

  // Called at a falling edge; drives one strobe and returns one cycle later
  // with the strobe still high (caller lowers it).
  task automatic push_word(input logic [31:0] w, input bit accepted);
    store_data_out = 1'b1;
    data_out       = w;
    if (accepted) expect_word(w);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      if (!busy) done = 1'b1;
      else @(negedge clk);
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- line receiver model ----------------
  bit         rx_active = 1'b0;
  logic [3:0] rx_pos;
  int         rx_sub;
  logic [9:0] rx_frame;
  int         rx_word_pos = 0;
  int         rx_gap = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      rx_active   = 1'b0;
      rx_word_pos = 0;
      rx_gap      = 0;
    end else if (!rx_active) begin
      if (uart_tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("rx_unexpected_frame", 32'd1, 32'd0);
          rx_frame = {1'b1, 8'h00, 1'b0};
        end else begin
          rx_frame = {1'b1, exp_q.pop_front(), 1'b0};
        end
        gap_q.push_back(rx_gap);
        if (rx_word_pos != 0) check("rx_intra_word_gap", 32'(rx_gap), 32'd0);
        rx_active = 1'b1;
        rx_pos    = 4'd0;
        rx_sub    = 1;
        rx_gap    = 0;
      end else begin
        rx_gap++;
      end
    end else begin
      check("rx_bit", 32'(uart_tx), 32'(rx_frame[rx_pos]));
      rx_sub++;
      if (rx_sub == D) begin
        rx_sub = 0;
        rx_pos = rx_pos + 4'd1;
        if (rx_pos == 4'd10) begin
          rx_active   = 1'b0;
          rx_word_pos = (rx_word_pos + 1) % 4;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] wa, wb, wc;
    int base, n, g;

    rstn           = 1'b0;
    data_out       = '0;
    store_data_out = 1'b0;
    clear_ovf      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx",    32'(uart_tx),    32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single store: line falls two cycles after the strobe, busy lasts 160.
    push_word(32'h44332211, 1'b1);            // now in cycle N+1
    store_data_out = 1'b0;
    check("t1_count_n1", 32'(fifo_count), 32'd1);
    check("t1_tx_n1",    32'(uart_tx),    32'd1);
    check("t1_busy_n1",  32'(busy),       32'd1);
    @(negedge clk);                           // N+2
    check("t1_tx_fall",  32'(uart_tx),    32'd0);
    check("t1_count_n2", 32'(fifo_count), 32'd0);
    repeat (159) @(negedge clk);              // N+161
    check("t1_busy_last", 32'(busy),    32'd1);
    check("t1_tx_stop",   32'(uart_tx), 32'd1);
    @(negedge clk);                           // N+162
    check("t1_busy_drop", 32'(busy), 32'd0);
    check("t1_all_bytes", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    // Back-to-back strobes: one extra idle-high cycle between the words.
    base = gap_q.size();
    push_word(32'hA5A5A5A5, 1'b1);
    check("t2_count_n1", 32'(fifo_count), 32'd1);
    push_word(32'h0000FF00, 1'b1);            // N+2
    store_data_out = 1'b0;
    check("t2_count_n2", 32'(fifo_count), 32'd1);
    check("t2_tx_n2",    32'(uart_tx),    32'd0);
    repeat (160) @(negedge clk);              // N+162, idle pop cycle
    check("t2_tx_gap",      32'(uart_tx),    32'd1);
    check("t2_count_pop",   32'(fifo_count), 32'd1);
    @(negedge clk);                           // N+163
    check("t2_tx_start2",   32'(uart_tx),    32'd0);
    check("t2_count_after", 32'(fifo_count), 32'd0);
    wait_idle(400);
    check("t2_frames", 32'(gap_q.size() - base), 32'd8);
    if (gap_q.size() > base + 4) check("t2_word_gap", 32'(gap_q[base+4]), 32'd1);
    check("t2_all_bytes", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    // Six consecutive strobes: one popped, four queued, sixth dropped.
    for (int i = 0; i < 6; i++) push_word($urandom, i < 5);   // ends at N+6
    store_data_out = 1'b0;
    check("t3_count_full", 32'(fifo_count), 32'd4);
    check("t3_overflow",   32'(overflow),   32'd1);
    repeat (4) @(negedge clk);                // N+10
    clear_ovf = 1'b1;
    @(negedge clk);                           // N+11
    clear_ovf = 1'b0;
    check("t3_ovf_cleared", 32'(overflow), 32'd0);
    repeat (151) @(negedge clk);              // N+162, pop cycle with FIFO full
    check("t3_count_at_pop", 32'(fifo_count), 32'd4);
    push_word($urandom, 1'b1);                // N+163
    store_data_out = 1'b0;
    check("t3_count_pushpop", 32'(fifo_count), 32'd4);
    check("t3_ovf_pushpop",   32'(overflow),   32'd0);
    repeat (7) @(negedge clk);                // N+170, full and not popping
    clear_ovf = 1'b1;
    push_word($urandom, 1'b0);                // N+171
    store_data_out = 1'b0;
    clear_ovf      = 1'b0;
    check("t3_ovf_set_wins", 32'(overflow),   32'd1);
    check("t3_count_drop",   32'(fifo_count), 32'd4);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check("t3_ovf_cleared2", 32'(overflow), 32'd0);
    wait_idle(1200);
    check("t3_all_bytes", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    // Random bursts of at most five strobes from idle: none may drop.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        push_word($urandom, 1'b1);
        store_data_out = 1'b0;
        g = $urandom_range(0, 3);
        repeat (g) @(negedge clk);
      end
      wait_idle(n * (40 * D + 1) + 50);
      check("rnd_all_bytes", 32'(exp_q.size()), 32'd0);
      check("rnd_overflow",  32'(overflow),     32'd0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    // Reset during a data bit of the second byte.
    wa = $urandom & 32'hFFFF00FF;
    wb = $urandom;
    push_word(wa, 1'b1);
    push_word(wb, 1'b1);                      // N+2
    store_data_out = 1'b0;
    repeat (48) @(negedge clk);               // N+50, byte 1 data bit 1
    check("t6_tx_before_rst",    32'(uart_tx),    32'd0);
    check("t6_count_before_rst", 32'(fifo_count), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("t6_tx_async",    32'(uart_tx),    32'd1);
    check("t6_count_async", 32'(fifo_count), 32'd0);
    check("t6_busy_async",  32'(busy),       32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    wc = $urandom;
    push_word(wc, 1'b1);
    store_data_out = 1'b0;
    check("t6_count_new", 32'(fifo_count), 32'd1);
    wait_idle(250);
    check("t6_all_bytes", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
